// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// The state encoding doubles as the occupancy count driven on the level port.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Value loaded into any data register that holds no valid beat.
  localparam int PIPE_CLR_VAL = 0;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Upstream stalls come from a state-decoded ready; FLUSH empties the stage and zeroes its data.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int CH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [1:0]       level
);

  localparam logic [DW-1:0] CLR_VAL = DW'(PIPE_CLR_VAL);

  pipe_state_t state;

  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid_in;
  logic clr_main;
  logic clr_skid;

  // All handshake outputs decode the state flop only, so in_ready never sees out_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign level     = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign ld_main_in   = !FLUSH && in_fire &&
                        ((state == EMPTY) || ((state == BUSY) && out_fire));
  assign ld_skid_in   = !FLUSH && in_fire && (state == BUSY) && !out_fire;
  assign ld_main_skid = !FLUSH && out_fire && (state == FULL);
  assign clr_main     = FLUSH || ((state == BUSY) && out_fire && !in_fire);
  assign clr_skid     = FLUSH || ld_main_skid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= EMPTY;
    end else if (FLUSH) begin
      state <= EMPTY;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the block order.
      case (state)
        EMPTY: if (in_fire) state <= BUSY;
        BUSY: begin
          if (in_fire && !out_fire)      state <= FULL;
          else if (!in_fire && out_fire) state <= EMPTY;
        end
        FULL:    if (out_fire) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_chan
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // NOTE: the data registers are reset too, so an empty stage never presents X downstream.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        main_q <= CLR_VAL;
        skid_q <= CLR_VAL;
      end else begin
        if (clr_main)          main_q <= CLR_VAL;
        else if (ld_main_in)   main_q <= in_data[k*DW +: DW];
        else if (ld_main_skid) main_q <= skid_q;

        if (clr_skid)        skid_q <= CLR_VAL;
        else if (ld_skid_in) skid_q <= in_data[k*DW +: DW];
      end
    end

    assign out_data[k*DW +: DW] = main_q;
  end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg with DW=32, CH=2.
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CH = 2;

  logic             CLK;
  logic             RST_N;
  logic             FLUSH;
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CH*DW-1:0] out_data;
  logic [1:0]       level;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DW(DW), .CH(CH)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .FLUSH    (FLUSH),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [1:0] exp_level,
                              input logic exp_ovalid, input logic exp_iready,
                              input logic [CH*DW-1:0] exp_data);
    checks++;
    if (level !== exp_level || out_valid !== exp_ovalid ||
        in_ready !== exp_iready || out_data !== exp_data) begin
      errors++;
      $display("FAIL %s: got level=%0d out_valid=%b in_ready=%b out_data=%h, expected level=%0d out_valid=%b in_ready=%b out_data=%h",
               name, level, out_valid, in_ready, out_data,
               exp_level, exp_ovalid, exp_iready, exp_data);
    end
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    FLUSH     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    expect_state("reset_values", 2'd0, 1'b0, 1'b1, '0);
    step();
    step();
    RST_N = 1'b1;
    step();
    expect_state("after_release", 2'd0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_stream();
    logic [CH*DW-1:0] beat;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat     = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      in_valid = 1'b1;
      in_data  = beat;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      step();
      expect_state($sformatf("stream_beat[%0d]", i), 2'd1, 1'b1, 1'b1, beat);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (level !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got level=%0d out_valid=%b expected level=0 out_valid=0",
               level, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    step();
    expect_state("bp_first", 2'd1, 1'b1, 1'b1, 64'h11);
    in_data = 64'h22;
    step();
    expect_state("bp_second_full", 2'd2, 1'b1, 1'b0, 64'h11);
    in_data = 64'h33;
    step();
    expect_state("bp_third_held", 2'd2, 1'b1, 1'b0, 64'h11);
    out_ready = 1'b1;
    step();
    expect_state("bp_release_0x22", 2'd1, 1'b1, 1'b1, 64'h22);
    step();
    expect_state("bp_release_0x33", 2'd1, 1'b1, 1'b1, 64'h33);
    in_valid = 1'b0;
    step();
    checks++;
    if (level !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got level=%0d out_valid=%b expected level=0 out_valid=0",
               level, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h44;
    step();
    in_data = 64'h55;
    step();
    expect_state("flush_pre_full", 2'd2, 1'b1, 1'b0, 64'h44);
    FLUSH   = 1'b1;
    in_data = 64'h66;
    step();
    expect_state("flush_result", 2'd0, 1'b0, 1'b1, '0);
    FLUSH     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("flush_no_leak[%0d]", i), 2'd0, 1'b0, 1'b1, '0);
    end
  endtask

  task automatic test_back_to_back();
    logic [CH*DW-1:0] beat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h0123_4567_89AB_CDEF;
    step();
    expect_state("b2b_prime", 2'd1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 20; i++) begin
      beat    = {$urandom(), $urandom()};
      in_data = beat;
      step();
      expect_state($sformatf("b2b[%0d]", i), 2'd1, 1'b1, 1'b1, beat);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    step();
    in_data = 64'h88;
    step();
    expect_state("arst_pre_full", 2'd2, 1'b1, 1'b0, 64'h77);
    in_valid = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    expect_state("arst_immediate", 2'd0, 1'b0, 1'b1, '0);
    step();
    #2;
    RST_N = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    out_ready = 1'b1;
    step();
    expect_state("arst_new_beat", 2'd1, 1'b1, 1'b1, 64'hDEAD);
    in_valid = 1'b0;
    step();
    checks++;
    if (level !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_drain: got level=%0d out_valid=%b expected level=0 out_valid=0",
               level, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg
